// File: rtl/vec_wb_if.sv
// Writeback queue bus: MEM-stage input, register-bank write port,
// decode forwarding lookup and status.
interface vec_wb_if #(
    parameter int LANES    = 12,
    parameter int ELEM_W   = 16,
    parameter int SCALAR_W = 21,
    parameter int NREGS    = 16,
    parameter int QDEPTH   = 4
);
    localparam int VW = LANES * ELEM_W;
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic                in_valid;
    logic                in_ready;
    logic [AW-1:0]       in_dest;
    logic                in_dest_type;
    logic [1:0]          in_wb;
    logic [VW-1:0]       in_mem_data;
    logic [VW-1:0]       in_alu_v;
    logic [SCALAR_W-1:0] in_alu_e;
    logic [LANES-1:0]    in_lane_mask;

    logic                rf_ready;
    logic                rf_we_v;
    logic                rf_we_e;
    logic [AW-1:0]       rf_waddr;
    logic [VW-1:0]       rf_wdata_v;
    logic [LANES-1:0]    rf_wmask;
    logic [SCALAR_W-1:0] rf_wdata_e;

    logic [AW-1:0]       fwd_addr;
    logic                fwd_type;
    logic                fwd_hit;
    logic [VW-1:0]       fwd_data_v;
    logic [LANES-1:0]    fwd_mask;

    logic [VW-1:0]       salida;
    logic [CW-1:0]       pending;

    modport master (
        output in_valid, in_dest, in_dest_type, in_wb,
        output in_mem_data, in_alu_v, in_alu_e, in_lane_mask,
        output rf_ready, fwd_addr, fwd_type,
        input  in_ready, rf_we_v, rf_we_e, rf_waddr,
        input  rf_wdata_v, rf_wmask, rf_wdata_e,
        input  fwd_hit, fwd_data_v, fwd_mask, salida, pending
    );

    modport slave (
        input  in_valid, in_dest, in_dest_type, in_wb,
        input  in_mem_data, in_alu_v, in_alu_e, in_lane_mask,
        input  rf_ready, fwd_addr, fwd_type,
        output in_ready, rf_we_v, rf_we_e, rf_waddr,
        output rf_wdata_v, rf_wmask, rf_wdata_e,
        output fwd_hit, fwd_data_v, fwd_mask, salida, pending
    );
endinterface

// File: rtl/vec_wb_queue.sv
// Vector writeback stage: result select, in-order queue draining into
// the register banks, and youngest-match forwarding to decode.
module vec_wb_queue #(
    parameter int LANES    = 12,
    parameter int ELEM_W   = 16,
    parameter int SCALAR_W = 21,
    parameter int NREGS    = 16,
    parameter int QDEPTH   = 4
) (
    input logic   clk,
    input logic   rst_n,
    vec_wb_if.slave io
);
    localparam int VW = LANES * ELEM_W;
    localparam int AW = $clog2(NREGS);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic             typ;
        logic [AW-1:0]    addr;
        logic [LANES-1:0] mask;
        logic [VW-1:0]    data;
    } ent_t;

    ent_t          mem_q [QDEPTH];
    ent_t          mem_d [QDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [VW-1:0] salida_q, salida_d;

    ent_t                new_ent;
    ent_t                head;
    logic [SCALAR_W-1:0] sel_e;
    logic                accept, push, pop;

    assign head = mem_q[rd_ptr_q];
    assign io.in_ready = cnt_q < CW'(QDEPTH);
    assign accept = io.in_valid && io.in_ready;
    assign push = accept && io.in_wb[0];
    assign pop = (cnt_q != '0) && io.rf_ready;

    always_comb begin
        sel_e = io.in_wb[1] ? io.in_mem_data[SCALAR_W-1:0] : io.in_alu_e;
        new_ent.typ = io.in_dest_type;
        new_ent.addr = io.in_dest;
        if (io.in_dest_type) begin
            new_ent.mask = io.in_lane_mask;
            new_ent.data = io.in_wb[1] ? io.in_mem_data : io.in_alu_v;
        end else begin
            new_ent.mask = '1;
            new_ent.data = {{(VW-SCALAR_W){1'b0}}, sel_e};
        end
    end

    always_comb begin
        mem_d = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d = cnt_q;
        salida_d = salida_q;
        if (accept) salida_d = new_ent.data;
        if (push) begin
            mem_d[wr_ptr_q] = new_ent;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q <= '0;
            salida_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q <= cnt_d;
            salida_q <= salida_d;
        end
    end

    // Write port is zeroed whenever no write is issued.
    assign io.rf_we_v = pop && head.typ;
    assign io.rf_we_e = pop && !head.typ;
    assign io.rf_waddr = pop ? head.addr : '0;
    assign io.rf_wdata_v = io.rf_we_v ? head.data : '0;
    assign io.rf_wmask = io.rf_we_v ? head.mask : '0;
    assign io.rf_wdata_e = io.rf_we_e ? head.data[SCALAR_W-1:0] : '0;
    assign io.salida = salida_q;
    assign io.pending = cnt_q;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        io.fwd_hit = 1'b0;
        io.fwd_data_v = '0;
        io.fwd_mask = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (CW'(i) < cnt_q &&
                mem_q[rd_ptr_q + PW'(i)].typ == io.fwd_type &&
                mem_q[rd_ptr_q + PW'(i)].addr == io.fwd_addr) begin
                io.fwd_hit = 1'b1;
                io.fwd_data_v = mem_q[rd_ptr_q + PW'(i)].data;
                io.fwd_mask = mem_q[rd_ptr_q + PW'(i)].mask;
            end
        end
    end
endmodule
